controller_block_sequencer: RTL and testbench
=============================================

// Module: controller_block_sequencer
// PURPOSE
//  Downstream consumer of the controller FIFO stack. Pops one full message block (WORDS x DBITS) per
//  transaction, zero-pads the final partial block, and maintains the BLAKE2 byte counter t.
//  Drives the compression core with init/next/final commands, one block at a time, and reports message done.
// PARAMETERS
//  DBITS     64   word width; must match the FIFO dbits
//  WORDS     16   words per block; must match the FIFO rd_pkt; block = DBITS*WORDS bits (1024 by default)
//  CNT_BITS  128  width of byte counter t
// PORTS
//  clk           in   1              clock
//  reset_n       in   1              async active-low reset
//  start         in   1              1-cycle pulse: begin new message; ignored unless IDLE
//  msg_final     in   1              level: next block popped is the last block of the message
//  final_bytes   in   8              valid bytes in last block, 0..BB (BB = DBITS*WORDS/8); sampled with msg_final
//  fifo_empty    in   1              FIFO empty flag
//  fifo_dout     in   DBITS*WORDS    FIFO block output; valid 1 cycle after fifo_rd
//  fifo_rd       out  1              1-cycle pop request
//  core_ready    in   1              core idle / accepts a command
//  core_init     out  1              1-cycle pulse: initialise core state
//  core_next     out  1              1-cycle pulse: compress non-final block
//  core_final    out  1              1-cycle pulse: compress final block (f0 set)
//  core_block    out  DBITS*WORDS    block presented to core; held stable from pulse until core_ready
//  core_counter  out  CNT_BITS       t value for current command
//  busy          out  1              high whenever FSM != IDLE
//  done          out  1              1-cycle pulse after final block accepted and core_ready returns
// BEHAVIOUR
//  Reset: async, all outputs 0, counter 0, FSM -> IDLE; reset mid-message abandons it with no done pulse.
//  FSM states and transitions:
//   IDLE   : start -> INIT
//   INIT   : wait core_ready; pulse core_init; clear counter -> WAITD
//   WAITD  : !fifo_empty && core_ready -> RD
//   RD     : pulse fifo_rd exactly once -> LATCH
//   LATCH  : capture fifo_dout; sample msg_final/final_bytes -> ISSUE
//   ISSUE  : non-final: counter += BB, pulse core_next;
//            final: counter += final_bytes, mask data, pulse core_final;
//            -> WAITC
//   WAITC  : core_ready && !last -> WAITD; core_ready && last -> DONE
//   DONE   : pulse done -> IDLE
//  Commands are issued only in ISSUE/INIT; at most one command outstanding. WAITC ignores core_ready in
//   the first cycle after the pulse (core drops ready on the next edge).
//  Latency: RD to command pulse = 2 cycles. Empty FIFO stalls in WAITD indefinitely; no timeout.
//  Masking: byte k = core_block[8k+7:8k]; bytes k >= final_bytes forced to 0. final_bytes = 0 means an
//   all-zero block and t unchanged (empty message). final_bytes > BB is clamped to BB.
//  Counter: core_counter = updated value in ISSUE (post-add); wraps modulo 2^CNT_BITS with no flag.
//  core_block and core_counter are registered and held constant until the next ISSUE.
//  start while busy: ignored. fifo_empty glitch between WAITD and RD: pop still issued; the FIFO ignores it.
//  msg_final is sampled only in LATCH; the host holds it stable from push of the last word until done.
// TESTING
//  1. Reset, start, one block with msg_final=1, final_bytes=3, dout bytes 0x61,0x62,0x63 followed by 0xFF
//     -> init, then core_final; block = 0x636261 with upper bytes 0; t=3; done pulses once.
//  2. Empty message: start, final block with final_bytes=0 -> core_final; block all-zero; t=0.
//  3. 3 blocks, last final_bytes=128 -> next(t=128), next(t=256), final(t=384); each RD->pulse = 2 cycles.
//  4. FIFO empty for 20 cycles between blocks -> remains in WAITD; no fifo_rd, no core pulse; resumes cleanly.
//  5. core_ready held low 10 cycles after next -> no further fifo_rd; core_block stable throughout.
//  6. reset_n low in WAITC of block 2 -> all outputs 0, IDLE, no done; new start runs normally with t from 0.

Source files
------------

// File: rtl/controller_block_sequencer_if.sv
// Sequencer-side bundle: host control, FIFO block read port and compression-core command port.
// master = sequencer, slave = host/FIFO/core environment.
interface controller_block_sequencer_if #(
  parameter int DBITS    = 64,
  parameter int WORDS    = 16,
  parameter int CNT_BITS = 128
);
  logic                     start;
  logic                     msg_final;
  logic [7:0]               final_bytes;
  logic                     fifo_empty;
  logic [DBITS*WORDS-1:0]   fifo_dout;
  logic                     fifo_rd;
  logic                     core_ready;
  logic                     core_init;
  logic                     core_next;
  logic                     core_final;
  logic [DBITS*WORDS-1:0]   core_block;
  logic [CNT_BITS-1:0]      core_counter;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, msg_final, final_bytes, fifo_empty, fifo_dout, core_ready,
    output fifo_rd, core_init, core_next, core_final, core_block, core_counter, busy, done
  );

  modport slave (
    output start, msg_final, final_bytes, fifo_empty, fifo_dout, core_ready,
    input  fifo_rd, core_init, core_next, core_final, core_block, core_counter, busy, done
  );
endinterface

// File: rtl/controller_block_sequencer.sv
// Pops one block per transaction, zero-pads the last block, tracks byte counter t and drives init/next/final.
// fifo_rd to command pulse is 2 cycles; stalls in WAITD on empty FIFO or busy core, one command outstanding.
module controller_block_sequencer #(
  parameter int DBITS    = 64,
  parameter int WORDS    = 16,
  parameter int CNT_BITS = 128
) (
  input  logic                        clk,
  input  logic                        reset_n,
  controller_block_sequencer_if.master bus
);
  localparam int BW = DBITS * WORDS;
  localparam int BB = BW / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_WAITD = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_ISSUE = 3'd5;
  localparam logic [2:0] S_WAITC = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]          state, state_nxt;
  logic                last_q;
  logic                skip_q;
  logic [BW-1:0]       blk_q, blk_masked;
  logic [CNT_BITS-1:0] cnt_q, add_bytes;
  logic                cmd_issue;
  int                  fb_eff;

  // Clamp the final byte count and zero every byte at or beyond it.
  always_comb begin
    fb_eff = int'(bus.final_bytes);
    if (fb_eff > BB) fb_eff = BB;
    blk_masked = bus.fifo_dout;
    if (bus.msg_final) begin
      for (int k = 0; k < BB; k++) begin
        if (k >= fb_eff) blk_masked[8*k +: 8] = 8'h00;
      end
    end
    add_bytes = bus.msg_final ? CNT_BITS'(fb_eff) : CNT_BITS'(BB);
  end

  // skip_q masks the stale core_ready seen in the cycle right after a command.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_INIT;
      S_INIT:  if (bus.core_ready) state_nxt = S_WAITD;
      S_WAITD: if (!bus.fifo_empty && bus.core_ready && !skip_q) state_nxt = S_RD;
      S_RD:    state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAITC;
      S_WAITC: if (bus.core_ready && !skip_q) state_nxt = last_q ? S_DONE : S_WAITD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.core_init  = (state == S_INIT) && bus.core_ready;
  assign bus.core_next  = (state == S_ISSUE) && !last_q;
  assign bus.core_final = (state == S_ISSUE) && last_q;
  assign bus.fifo_rd    = (state == S_RD);
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.core_block   = blk_q;
  assign bus.core_counter = cnt_q;
  assign cmd_issue = bus.core_init | bus.core_next | bus.core_final;

  // Block and post-add counter are loaded on the LATCH edge so both are valid for the whole ISSUE pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      last_q <= 1'b0;
      skip_q <= 1'b0;
      blk_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      skip_q <= cmd_issue;
      if (state == S_INIT && bus.core_ready) cnt_q <= '0;
      if (state == S_LATCH) begin
        last_q <= bus.msg_final;
        blk_q  <= blk_masked;
        cnt_q  <= cnt_q + add_bytes;
      end
    end
  end
endmodule

// File: tb/tb_controller_block_sequencer.sv
// Randomized scoreboard bench: host/FIFO/core models drive the sequencer, a negedge monitor checks commands.
module tb_controller_block_sequencer;
  localparam int DBITS = 64, WORDS = 16, CNT_BITS = 128;
  localparam int BW = DBITS * WORDS, BB = BW / 8;
  localparam int K_INIT = 0, K_NEXT = 1, K_FINAL = 2, K_DONE = 3;

  typedef struct { int kind; logic [BW-1:0] blk; logic [CNT_BITS-1:0] cnt; } exp_t;
  typedef struct { logic [BW-1:0] dat; logic last; logic [7:0] fb; } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  controller_block_sequencer_if #(.DBITS(DBITS), .WORDS(WORDS), .CNT_BITS(CNT_BITS)) bus();
  controller_block_sequencer #(.DBITS(DBITS), .WORDS(WORDS), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  ent_t fq[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, rd_cyc = -100, core_lat = 2, busy_left = 0, drop_in = 0, cmd_cnt = 0;
  logic [BW-1:0] held_blk;
  bit hold_vld = 0;

  task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] rnd_block();
    logic [BW-1:0] r;
    for (int j = 0; j < BW/32; j++) r[32*j +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [BW-1:0] low_mask(input int n);
    logic [BW-1:0] one;
    one = 1;
    if (n >= BB) return '1;
    return (one << (8*n)) - one;
  endfunction

  function automatic bit core_free();
    return bus.core_ready && busy_left == 0 && drop_in == 0;
  endfunction

  // Monitor, FIFO model and core model: everything sampled and driven at negedge.
  always @(negedge clk) begin
    exp_t e;
    ent_t b;
    bit cmd;
    int kind_now;
    cyc++;
    cmd = bus.core_init | bus.core_next | bus.core_final;
    kind_now = bus.core_init ? K_INIT : (bus.core_next ? K_NEXT : K_FINAL);
    if (!reset_n) begin
      chk("reset_ctl", {bus.fifo_rd, bus.core_init, bus.core_next, bus.core_final, bus.busy, bus.done} == 6'b0,
          {bus.fifo_rd, bus.core_init, bus.core_next, bus.core_final, bus.busy, bus.done}, 0);
      chk("reset_data", bus.core_counter == '0 && bus.core_block == '0, bus.core_counter, 0);
      bus.core_ready = 1'b1;
      bus.fifo_dout = '0;
      bus.msg_final = 1'b0;
      bus.final_bytes = 8'd0;
      busy_left = 0;
      drop_in = 0;
      hold_vld = 0;
    end else begin
      if (cmd) begin
        chk("cmd_core_free", core_free(), {busy_left, drop_in}, 0);
        cmd_cnt++;
        if (exp_q.size() == 0) chk("cmd_unexpected", 1'b0, kind_now, 0);
        else begin
          e = exp_q.pop_front();
          chk("cmd_kind", kind_now == e.kind, kind_now, e.kind);
          if (e.kind != K_INIT) begin
            chk("counter", bus.core_counter == e.cnt, bus.core_counter, e.cnt);
            for (int w = 0; w < WORDS; w++)
              chk($sformatf("block_w%0d", w), bus.core_block[64*w +: 64] == e.blk[64*w +: 64],
                  bus.core_block[64*w +: 64], e.blk[64*w +: 64]);
            chk("rd_to_cmd", cyc - rd_cyc == 2, cyc - rd_cyc, 2);
          end
        end
        held_blk = bus.core_block;
        hold_vld = 1;
      end else if (hold_vld && !bus.core_ready) begin
        chk("block_stable", bus.core_block == held_blk, bus.core_block[127:0], held_blk[127:0]);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1'b0, 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", e.kind == K_DONE, K_DONE, e.kind);
        end
      end
      if (bus.fifo_rd) begin
        chk("pop_legal", fq.size() != 0 && core_free(), fq.size(), 1);
        rd_cyc = cyc;
        if (fq.size() != 0) begin
          b = fq.pop_front();
          bus.fifo_dout = b.dat;
          bus.msg_final = b.last;
          bus.final_bytes = b.fb;
        end
      end
      // Core keeps ready high for one more edge after a command, then stays busy core_lat cycles.
      if (drop_in > 0) begin
        drop_in--;
        if (drop_in == 0) begin
          bus.core_ready = 1'b0;
          busy_left = core_lat;
        end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.core_ready = 1'b1;
      end
      if (cmd) drop_in = 2;
    end
    bus.fifo_empty = (fq.size() == 0);
  end

  task automatic pulse_start();
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((exp_q.size() != 0 || bus.busy) && budget < 4000);
    chk("msg_complete", budget < 4000, budget, 4000);
  endtask

  task automatic send_msg(input int nblk, input int fb, input int gap, input int lat,
                          input bit fixed, input logic [BW-1:0] fdat);
    exp_t e;
    ent_t b;
    ent_t blks[$];
    logic [CNT_BITS-1:0] t;
    int n;
    t = '0;
    core_lat = lat;
    e.kind = K_INIT; e.blk = '0; e.cnt = '0;
    exp_q.push_back(e);
    for (int i = 0; i < nblk; i++) begin
      b.dat = (fixed && i == 0) ? fdat : rnd_block();
      b.last = (i == nblk - 1);
      b.fb = 8'(fb);
      if (b.last) begin
        n = (fb > BB) ? BB : fb;
        t = t + CNT_BITS'(n);
        e.kind = K_FINAL;
        e.blk = b.dat & low_mask(n);
      end else begin
        t = t + CNT_BITS'(BB);
        e.kind = K_NEXT;
        e.blk = b.dat;
      end
      e.cnt = t;
      exp_q.push_back(e);
      blks.push_back(b);
    end
    e.kind = K_DONE; e.blk = '0; e.cnt = '0;
    exp_q.push_back(e);
    pulse_start();
    foreach (blks[i]) begin
      if (i > 0) begin
        repeat (gap) @(posedge clk);
        if (i == 1) pulse_start();
      end
      @(posedge clk); #2 fq.push_back(blks[i]);
    end
    wait_idle();
  endtask

  initial begin
    logic [BW-1:0] d;
    exp_t e;
    ent_t b;
    int base, budget;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    d = '1;
    d[23:0] = 24'h636261;
    send_msg(1, 3, 0, 2, 1'b1, d);
    send_msg(1, 0, 0, 2, 1'b0, '0);
    send_msg(3, 128, 1, 2, 1'b0, '0);
    send_msg(3, 100, 20, 2, 1'b0, '0);
    send_msg(3, 64, 0, 10, 1'b0, '0);

    // Abort in WAITC of block 2, then a fresh message must restart t from 0.
    core_lat = 8;
    @(posedge clk); #2;
    e.kind = K_INIT; e.blk = '0; e.cnt = '0;
    exp_q.push_back(e);
    for (int i = 0; i < 2; i++) begin
      b.dat = rnd_block(); b.last = 1'b0; b.fb = 8'd0;
      e.kind = K_NEXT; e.blk = b.dat; e.cnt = CNT_BITS'(BB * (i + 1));
      exp_q.push_back(e);
      fq.push_back(b);
    end
    base = cmd_cnt;
    pulse_start();
    budget = 0;
    while (cmd_cnt < base + 3 && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    chk("abort_reached", budget < 500, budget, 500);
    @(posedge clk); #2 reset_n = 1'b0;
    exp_q.delete();
    fq.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    send_msg(2, 50, 1, 3, 1'b0, '0);

    for (int m = 0; m < 12; m++)
      send_msg($urandom_range(1, 4), $urandom_range(0, 255), $urandom_range(0, 4),
               $urandom_range(1, 5), 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
